// File: rtl/spi_controller.sv
// SPI mode-0 controller producing 16-bit [R/W][ADDR 7b][DATA 8b] frames, MSB first,
// with trailing hold and nCS-high gap; captures CIPO during the data byte.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  input  logic       CIPO
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_r, state_nxt_s;
  logic [7:0]  div_cnt_r, div_cnt_nxt_s;
  logic [3:0]  bit_cnt_r, bit_cnt_nxt_s;
  logic [15:0] shift_r, shift_nxt_s;
  logic [7:0]  cap_r, cap_nxt_s;
  logic [7:0]  rdata_r, rdata_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        done_r, done_nxt_s;
  logic        ncs_r, ncs_nxt_s;
  logic        sclk_r, sclk_nxt_s;
  logic        copi_r, copi_nxt_s;
  logic        div_wrap_s;

  assign div_wrap_s = (div_cnt_r == DIV_LAST);

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt_s   = state_r;
    div_cnt_nxt_s = div_cnt_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    cap_nxt_s     = cap_r;
    rdata_nxt_s   = rdata_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    ncs_nxt_s     = ncs_r;
    sclk_nxt_s    = sclk_r;
    copi_nxt_s    = copi_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s   = SHIFT;
          shift_nxt_s   = {rw, addr, wdata};
          copi_nxt_s    = rw;
          ncs_nxt_s     = 1'b0;
          sclk_nxt_s    = 1'b0;
          busy_nxt_s    = 1'b1;
          div_cnt_nxt_s = 8'd0;
          bit_cnt_nxt_s = 4'd15;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      SHIFT: begin
        if (!div_wrap_s) begin
          div_cnt_nxt_s = div_cnt_r + 8'd1;
        end else begin
          div_cnt_nxt_s = 8'd0;
          if (!sclk_r) begin
            sclk_nxt_s = 1'b1;
          end else begin
            // Last cycle of the high phase: sample CIPO, then fall and advance COPI.
            sclk_nxt_s = 1'b0;
            if (bit_cnt_r <= 4'd7) begin
              cap_nxt_s = {cap_r[6:0], CIPO};
            end else begin
              cap_nxt_s = cap_r;
            end
            if (bit_cnt_r == 4'd0) begin
              state_nxt_s = HOLD;
            end else begin
              bit_cnt_nxt_s = bit_cnt_r - 4'd1;
              shift_nxt_s   = {shift_r[14:0], 1'b0};
              copi_nxt_s    = shift_r[14];
            end
          end
        end
      end

      HOLD: begin
        if (!div_wrap_s) begin
          div_cnt_nxt_s = div_cnt_r + 8'd1;
        end else begin
          div_cnt_nxt_s = 8'd0;
          bit_cnt_nxt_s = 4'd1;
          ncs_nxt_s     = 1'b1;
          copi_nxt_s    = 1'b0;
          state_nxt_s   = GAP;
        end
      end

      GAP: begin
        // Two half-period passes, tracked by the otherwise idle bit counter.
        if (!div_wrap_s) begin
          div_cnt_nxt_s = div_cnt_r + 8'd1;
        end else begin
          div_cnt_nxt_s = 8'd0;
          if (bit_cnt_r != 4'd0) begin
            bit_cnt_nxt_s = bit_cnt_r - 4'd1;
          end else begin
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
            rdata_nxt_s = cap_r;
          end
        end
      end

      default: begin
        state_nxt_s   = IDLE;
        div_cnt_nxt_s = 8'd0;
        bit_cnt_nxt_s = 4'd0;
        busy_nxt_s    = 1'b0;
        ncs_nxt_s     = 1'b1;
        sclk_nxt_s    = 1'b0;
        copi_nxt_s    = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      div_cnt_r <= 8'd0;
      bit_cnt_r <= 4'd0;
      shift_r   <= 16'h0000;
      cap_r     <= 8'h00;
      rdata_r   <= 8'h00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ncs_r     <= 1'b1;
      sclk_r    <= 1'b0;
      copi_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      div_cnt_r <= div_cnt_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
      cap_r     <= cap_nxt_s;
      rdata_r   <= rdata_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      ncs_r     <= ncs_nxt_s;
      sclk_r    <= sclk_nxt_s;
      copi_r    <= copi_nxt_s;
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign rdata = rdata_r;
  assign nCS   = ncs_r;
  assign SCLK  = sclk_r;
  assign COPI  = copi_r;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: peripheral register-file model, scoreboard of
// expected frames/read data, table-driven transactions plus reset and CLK_DIV=2 sequences.
module tb_spi_controller;

  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, rw, CIPO;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;
  logic       busy, done, nCS, SCLK, COPI;

  logic       start2, rw2, cipo2;
  logic [6:0] addr2;
  logic [7:0] wdata2, rdata2;
  logic       busy2, done2, ncs2, sclk2, copi2;

  spi_controller #(.CLK_DIV(D)) u_dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .nCS(nCS), .SCLK(SCLK), .COPI(COPI), .CIPO(CIPO)
  );

  spi_controller #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .rw(rw2), .addr(addr2), .wdata(wdata2),
    .busy(busy2), .done(done2), .rdata(rdata2), .nCS(ncs2), .SCLK(sclk2), .COPI(copi2), .CIPO(cipo2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] frame;
    logic [7:0]  rdata;
  } exp_t;
  exp_t sb[$];

  // Peripheral model and line monitors for the CLK_DIV=4 instance.
  logic [7:0]  regs [0:127];
  logic [15:0] p_shift;
  int          p_rises;
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;
  int          ncs_high_run = 0, last_gap = 0, copi_viol = 0;
  logic        aborting = 1'b0;
  logic [7:0]  cipo_byte;

  task automatic observe();
    if (prev_ncs && !nCS) begin
      last_gap = ncs_high_run;
      p_rises  = 0;
      p_shift  = 16'h0000;
    end
    if (!nCS && !prev_sclk && SCLK) begin
      p_shift = {p_shift[14:0], COPI};
      p_rises++;
    end
    if (!prev_ncs && nCS && !aborting) begin
      check("frame_bits", p_rises, 16);
      check("frame", p_shift, sb[0].frame);
    end
    if (!prev_ncs && nCS && p_rises == 16 && p_shift[15]) regs[p_shift[14:8]] = p_shift[7:0];
    if (prev_sclk && SCLK && COPI !== prev_copi) copi_viol++;
    if (prev_sclk && !SCLK && p_rises >= 8 && p_rises <= 15) CIPO = cipo_byte[15 - p_rises];
    ncs_high_run = nCS ? ncs_high_run + 1 : 0;
    prev_ncs  = nCS;
    prev_sclk = SCLK;
    prev_copi = COPI;
  endtask

  task automatic idle_check(input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      observe();
      if (done || busy) bad++;
    end
    check("idle_quiet", bad, 0);
  endtask

  task automatic run_frame(input logic f_rw, input logic [6:0] f_addr, input logic [7:0] f_wdata,
                           input logic [7:0] f_cipo, input logic [7:0] f_exp, input bit pre_started,
                           input int glitch_a, input int glitch_b, input int rst_cyc, input bit chain,
                           input logic n_rw, input logic [6:0] n_addr, input logic [7:0] n_wdata,
                           input logic [7:0] n_exp);
    int c, busy_cnt, dones, rd_viol;
    bit finished;
    logic [7:0] rdata_hold;
    exp_t e;
    cipo_byte = f_cipo;
    if (!pre_started) begin
      @(negedge clk);
      observe();
      start = 1'b1; rw = f_rw; addr = f_addr; wdata = f_wdata;
      e.frame = {f_rw, f_addr, f_wdata};
      e.rdata = f_exp;
      sb.push_back(e);
    end
    rdata_hold = rdata;
    c = 0; busy_cnt = 0; dones = 0; rd_viol = 0; finished = 1'b0; copi_viol = 0;
    while (!finished && c < 35 * D + 20) begin
      @(negedge clk);
      c++;
      observe();
      if (c == 1) check("first_cycle", {nCS, SCLK, COPI, busy}, {1'b0, 1'b0, f_rw, 1'b1});
      if (busy) busy_cnt++;
      if (done) dones++;
      if (busy && rdata !== rdata_hold) rd_viol++;
      if (c == glitch_a || c == glitch_b) begin
        start = 1'b1; rw = ~f_rw; addr = ~f_addr; wdata = ~f_wdata;
      end else begin
        start = 1'b0;
      end
      if (c == rst_cyc) begin
        aborting = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_outputs", {nCS, SCLK, COPI, busy, done}, 5'b10000);
        @(negedge clk);
        rst = 1'b0;
        observe();
        aborting = 1'b0;
        void'(sb.pop_front());
        finished = 1'b1;
      end else if (done) begin
        check("done_latency", c, 35 * D + 1);
        check("busy_width", busy_cnt, 35 * D);
        check("done_count", dones, 1);
        check("rdata", rdata, sb[0].rdata);
        void'(sb.pop_front());
        check("copi_stable", copi_viol, 0);
        check("rdata_hold", rd_viol, 0);
        if (chain) begin
          start = 1'b1; rw = n_rw; addr = n_addr; wdata = n_wdata;
          e.frame = {n_rw, n_addr, n_wdata};
          e.rdata = n_exp;
          sb.push_back(e);
        end
        finished = 1'b1;
      end
    end
    if (!finished) check("timeout", c, 35 * D + 1);
  endtask

  // CLK_DIV=2 instance: half-period widths, COPI stability, busy width, decoded frame.
  task automatic run_d2(input logic f_rw, input logic [6:0] f_addr, input logic [7:0] f_wdata);
    int c, busy_w, hi_run, lo_run, bad_hi, bad_lo, copi_bad, rises;
    logic [15:0] got;
    logic psclk, pcopi;
    bit fin;
    c = 0; busy_w = 0; hi_run = 0; lo_run = 0; bad_hi = 0; bad_lo = 0; copi_bad = 0; rises = 0;
    got = 16'h0000; psclk = 1'b0; pcopi = 1'b0; fin = 1'b0;
    @(negedge clk);
    start2 = 1'b1; rw2 = f_rw; addr2 = f_addr; wdata2 = f_wdata; cipo2 = 1'b1;
    while (!fin && c < 100) begin
      @(negedge clk);
      c++;
      start2 = 1'b0;
      if (busy2) busy_w++;
      if (!ncs2 && sclk2 && copi2 !== pcopi) copi_bad++;
      if (!ncs2) begin
        if (sclk2 && !psclk) begin
          if (lo_run != 2) bad_lo++;
          got = {got[14:0], copi2};
          rises++;
          hi_run = 1;
        end else if (!sclk2 && psclk) begin
          if (hi_run != 2) bad_hi++;
          lo_run = 1;
        end else if (sclk2) begin
          hi_run++;
        end else begin
          lo_run++;
        end
      end else begin
        lo_run = 0;
      end
      psclk = sclk2;
      pcopi = copi2;
      if (done2) begin
        fin = 1'b1;
        check("d2_done_latency", c, 71);
        check("d2_busy_width", busy_w, 70);
        check("d2_low_phase", bad_lo, 0);
        check("d2_high_phase", bad_hi, 0);
        check("d2_copi_stable", copi_bad, 0);
        check("d2_rises", rises, 16);
        check("d2_frame", got, {f_rw, f_addr, f_wdata});
        check("d2_rdata", rdata2, 8'hFF);
      end
    end
    if (!fin) check("d2_timeout", c, 71);
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] cipo;
    bit         chain;
    int         ga;
    int         gb;
    bit         gap_chk;
    logic [7:0] exp_rdata;
    logic [6:0] chk_addr;
    logic [7:0] chk_val;
  } row_t;
  row_t tbl [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit pre;
    int ni;
    tbl[0] = '{1'b1, 7'h00, 8'hF0, 8'h00, 1'b0, 0,  0,  1'b0, 8'h00, 7'h00, 8'hF0};
    tbl[1] = '{1'b1, 7'h04, 8'h80, 8'h5A, 1'b1, 0,  0,  1'b0, 8'h5A, 7'h04, 8'h80};
    tbl[2] = '{1'b1, 7'h02, 8'h3C, 8'hC3, 1'b0, 0,  0,  1'b1, 8'hC3, 7'h02, 8'h3C};
    tbl[3] = '{1'b0, 7'h01, 8'h77, 8'hA5, 1'b0, 0,  0,  1'b0, 8'hA5, 7'h01, 8'h00};
    tbl[4] = '{1'b1, 7'h10, 8'h55, 8'h33, 1'b0, 10, 70, 1'b0, 8'h33, 7'h10, 8'h55};
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;

    rst = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00; CIPO = 1'b0;
    start2 = 1'b0; rw2 = 1'b0; addr2 = 7'h00; wdata2 = 8'h00; cipo2 = 1'b0;
    p_shift = 16'h0000; p_rises = 0; cipo_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", {nCS, SCLK, COPI, busy, done, rdata}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    check("reset_state_d2", {ncs2, sclk2, copi2, busy2, done2, rdata2}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    rst = 1'b0;
    idle_check(3);

    for (int i = 0; i < 5; i++) begin
      pre = (i > 0) && tbl[i - 1].chain;
      ni  = (i < 4) ? i + 1 : i;
      run_frame(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].cipo, tbl[i].exp_rdata, pre,
                tbl[i].ga, tbl[i].gb, 0, tbl[i].chain,
                tbl[ni].rw, tbl[ni].addr, tbl[ni].wdata, tbl[ni].exp_rdata);
      if (!tbl[i].chain) begin
        check("reg_value", regs[tbl[i].chk_addr], tbl[i].chk_val);
        if (tbl[i].gap_chk) check("ncs_gap", last_gap, 2 * D + 1);
        idle_check(20);
      end
    end
    check("reg_pwm_duty", regs[7'h04], 8'h80);

    // Reset in the middle of a write: nothing lands, rdata cleared, no done.
    run_frame(1'b1, 7'h00, 8'hAA, 8'h00, 8'h00, 1'b0, 0, 0, 50, 1'b0, 1'b0, 7'h00, 8'h00, 8'h00);
    check("rst_rdata", rdata, 8'h00);
    check("rst_no_write", regs[7'h00], 8'hF0);
    idle_check(20);
    run_frame(1'b1, 7'h00, 8'h0F, 8'h96, 8'h96, 1'b0, 0, 0, 0, 1'b0, 1'b0, 7'h00, 8'h00, 8'h00);
    check("post_rst_write", regs[7'h00], 8'h0F);
    idle_check(5);

    run_d2(1'b1, 7'h2B, 8'h9C);
    run_d2(1'b0, 7'h55, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI mode-0 controller that drives the 16-bit write/read frames expected by the on-chip SPI peripheral register file: frame = [R/W][ADDR 7b][DATA 8b], MSB first.
- Sits in the test/bring-up harness, or in a host-side wrapper on the same system clock.
- Converts a single-cycle start request into a complete nCS/SCLK/COPI transaction.
- Captures CIPO during the data byte for future read-back.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period. Legal range 2..255. Must be ≥4 when driving the 2-stage-synchronised peripheral.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle transaction request; honoured only when busy=0.
- rw  in  1  1 = write, 0 = read; sampled with start.
- addr  in  7  register address; sampled with start.
- wdata  in  8  write data; sampled with start. Sent as-is, including on reads.
- busy  out  1  high while a frame or its trailing gap is in progress.
- done  out  1  one-cycle pulse at end of transaction.
- rdata  out  8  CIPO bits captured during frame bits 7..0; valid from done.
- nCS  out  1  chip select, active-low.
- SCLK  out  1  serial clock, idle low.
- COPI  out  1  controller-out data.
- CIPO  in  1  controller-in data. Sampled raw; synchronisation is the caller's concern.

Behaviour:
- All outputs are registered; no combinational paths from inputs to outputs.
- Reset values: nCS=1, SCLK=0, COPI=0, busy=0, done=0, rdata=0x00. FSM returns to IDLE and all counters clear.
- FSM states: IDLE, SHIFT, HOLD, GAP.
- IDLE:
  - On start=1, latch frame = {rw, addr, wdata} into a 16-bit shift register and move to SHIFT.
  - On the next cycle: nCS=0, SCLK=0, COPI=frame[15], busy=1.
  - start is ignored while busy=1, with no effect on the frame in progress.
- SHIFT: 16 bit periods, bit index 15 down to 0.
  - Each bit period is CLK_DIV cycles with SCLK=0, then CLK_DIV cycles with SCLK=1.
  - COPI changes only on the first cycle of each low phase, i.e. coincident with the SCLK falling edge (or the nCS falling edge for bit 15). COPI is stable for the whole high phase.
  - CIPO is sampled on the last cycle of each high phase.
  - For bits 7..0, the sampled value shifts into an internal byte, MSB first.
  - After the bit-0 high phase: SCLK→0 and go to HOLD.
- HOLD: CLK_DIV cycles with nCS=0 and SCLK=0; COPI holds bit 0. Then nCS→1 and go to GAP.
- GAP: 2*CLK_DIV cycles with nCS=1. This guarantees the peripheral's synchroniser sees nCS high before the next falling edge.
  - On the last GAP cycle, the next-state logic sets busy→0, done→1 (one cycle) and rdata←captured byte.
  - COPI returns to 0.
- Latency:
  - busy is high for exactly 35*CLK_DIV cycles: 32 shift, 1 hold, 2 gap.
  - done occurs 35*CLK_DIV+1 cycles after the start cycle.
- Back-to-back: start presented in the same cycle done=1 is accepted (busy=0 that cycle). nCS then falls on the following cycle, giving exactly 2*CLK_DIV+1 high cycles between frames.
- Reads (rw=0): frame is still shifted fully. The peripheral ignores it; rdata reflects CIPO.
- Counters:
  - Half-period counter is 8 bits and wraps to 0 at CLK_DIV-1.
  - Bit counter is 4 bits, 15→0. Terminal detection is at 0, with no underflow.
- Reset mid-frame: nCS rises immediately (asynchronously), SCLK and COPI go to 0, and no done pulse is produced. The peripheral's partial count is discarded on its next nCS falling edge.
- rdata holds its value between transactions. It is not modified during a frame.

Test Plan:
- CLK_DIV=4; start, rw=1, addr=0x00, wdata=0xF0 → COPI bit sequence 1000_0000_1111_0000 on 16 SCLK rising edges. Attached peripheral model sets en_reg_out_7_0=0xF0. busy high for 140 cycles, single done pulse.
- Write addr=0x04, wdata=0x80, then write addr=0x02, wdata=0x3C with start on the done cycle → peripheral pwm_duty_cycle=0x80 and en_reg_pwm_7_0=0x3C. nCS high for exactly 9 cycles between frames.
- Read rw=0, addr=0x01; bench drives CIPO=0xA5 MSB-first, changing on SCLK falling edges during bits 7..0 → rdata=0xA5 at done. Peripheral registers unchanged.
- start pulsed again at cycles 10 and 70 of a frame carrying wdata=0x55 → both ignored. Transmitted frame unaltered, exactly one done.
- rst asserted at cycle 50 of a write to addr=0x00 → nCS=1 and SCLK=0 the same cycle, no done. Next full write of 0x0F lands correctly (en_reg_out_7_0=0x0F).
- CLK_DIV=2 sweep → each SCLK half-period is exactly 2 clk cycles, no COPI transition while SCLK=1, busy width 70 cycles.
